// File: rtl/normalizer.sv
// normalizer: iterative left-normalizer for a 16-bit mantissa with a biased exponent, bounded shift per cycle.
module normalizer #(
  parameter int EXP_W    = 8,
  parameter int MAX_STEP = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      value,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic [EXP_W-1:0] exp_out,
  output logic [4:0]       shift_count,
  output logic             zero,
  output logic             denorm
);
  localparam int MS = (MAX_STEP > 15) ? 15 : MAX_STEP;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [15:0] r_m, r_result;
  logic [EXP_W-1:0] r_e, r_exp;
  logic [4:0] r_c, r_cnt, w_lz, w_ecap, w_lim, w_step;
  logic r_zero, r_denorm, w_stop;
  always_comb begin
    w_lz = 5'd16;
    for (int i = 0; i < 16; i++)
      if (r_m[i]) w_lz = 5'(15 - i);
  end
  // Exponent is capped to 15 first so the min() works for any EXP_W.
  assign w_ecap = (32'(r_e) > 15) ? 5'd15 : 5'(r_e);
  assign w_lim  = (w_ecap < 5'(MS)) ? w_ecap : 5'(MS);
  assign w_step = (w_lz < w_lim) ? w_lz : w_lim;
  assign w_stop = (r_m == 16'd0) || r_m[15] || (r_e == '0);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && in_valid) w_next = SHIFT;
    else if (r_state == SHIFT && w_stop) w_next = DONE;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m      <= '0;
      r_e      <= '0;
      r_c      <= '0;
      r_result <= '0;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_denorm <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_m <= value;
      r_e <= exp_in;
      r_c <= '0;
    end else if (r_state == SHIFT && w_stop) begin
      r_result <= r_m;
      r_exp    <= (r_m == 16'd0) ? '0 : r_e;
      r_cnt    <= r_c;
      r_zero   <= (r_m == 16'd0);
      r_denorm <= (r_m != 16'd0) && !r_m[15];
    end else if (r_state == SHIFT) begin
      r_m <= r_m << w_step;
      r_e <= r_e - EXP_W'(w_step);
      r_c <= r_c + w_step;
    end
  end
  assign in_ready    = (r_state == IDLE) && reset_n;
  assign out_valid   = (r_state == DONE);
  assign result      = r_result;
  assign exp_out     = r_exp;
  assign shift_count = r_cnt;
  assign zero        = r_zero;
  assign denorm      = r_denorm;
endmodule
